// File: rtl/ysyx_25040111_alu_dec.sv
// RV32I decode stage feeding the ALU control interface. A registered output slot
// plus one skid entry lets in_ready come straight from a flop.
module ysyx_25040111_alu_dec #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [2:0]        out_opt,
  output logic              out_ext,
  output logic              out_sign,
  output logic              out_negate,
  output logic              out_snpc,
  output logic [1:0]        out_a1_sel,
  output logic              out_a2_imm,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wen,
  output logic [2:0]        out_class
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] OPT_ADD   = 3'b001;
  localparam logic [2:0] OPT_ANDOR = 3'b010;
  localparam logic [2:0] OPT_XOR   = 3'b011;
  localparam logic [2:0] OPT_SLL   = 3'b100;
  localparam logic [2:0] OPT_SR    = 3'b101;
  localparam logic [2:0] OPT_LT    = 3'b110;
  localparam logic [2:0] OPT_EQ    = 3'b111;

  localparam logic [1:0] A1_RS1  = 2'b00;
  localparam logic [1:0] A1_PC   = 2'b01;
  localparam logic [1:0] A1_ZERO = 2'b10;

  localparam logic [2:0] CLS_ALU = 3'd0;
  localparam logic [2:0] CLS_BR  = 3'd1;
  localparam logic [2:0] CLS_JMP = 3'd2;
  localparam logic [2:0] CLS_LD  = 3'd3;
  localparam logic [2:0] CLS_ST  = 3'd4;
  localparam logic [2:0] CLS_SYS = 3'd5;
  localparam logic [2:0] CLS_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [2:0]        opt;
    logic              ext;
    logic              sign;
    logic              negate;
    logic              snpc;
    logic [1:0]        a1_sel;
    logic              a2_imm;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic [2:0]        cls;
  } bundle_t;

  function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // A register field naming a register beyond 2^REG_AW (e.g. x16+ on RV32E).
  function automatic logic idx_bad(input logic [4:0] f);
    return (f >> REG_AW) != 5'd0;
  endfunction

  function automatic bundle_t decode(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    bundle_t            b;
    logic [6:0]         op;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               f7_std;
    logic               is_imm;
    logic               legal;
    logic               use_rd;
    logic               use_rs1;
    logic               use_rs2;
    logic signed [31:0] imm32;
    b       = '0;
    op      = inst[6:0];
    f3      = inst[14:12];
    f7      = inst[31:25];
    f7_std  = (f7 == 7'h00) || (f7 == 7'h20);
    is_imm  = (op == OP_OPIMM);
    legal   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    b.pc    = pc;
    b.rs1   = inst[15 +: REG_AW];
    b.rs2   = inst[20 +: REG_AW];
    b.rd    = inst[7 +: REG_AW];
    case (op)
      OP_LUI, OP_AUIPC: begin
        b.a1_sel = (op == OP_LUI) ? A1_ZERO : A1_PC;
        b.a2_imm = 1'b1;
        b.opt    = OPT_ADD;
        b.cls    = CLS_ALU;
        imm32    = imm_u(inst);
        use_rd   = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        // ALU produces the link address pc+4; the target uses imm separately.
        b.a1_sel = A1_PC;
        b.snpc   = 1'b1;
        b.opt    = OPT_ADD;
        b.cls    = CLS_JMP;
        use_rd   = 1'b1;
        use_rs1  = (op == OP_JALR);
        imm32    = (op == OP_JAL) ? imm_j(inst) : imm_i(inst);
        if (op == OP_JALR && f3 != 3'b000) legal = 1'b0;
      end
      OP_BRANCH: begin
        b.a1_sel = A1_RS1;
        b.cls    = CLS_BR;
        b.ext    = 1'b1;
        imm32    = imm_b(inst);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        case (f3)
          3'b000: b.opt = OPT_EQ;
          3'b001: begin b.opt = OPT_EQ; b.negate = 1'b1; end
          3'b100: begin b.opt = OPT_LT; b.sign = 1'b1; end
          3'b101: begin b.opt = OPT_LT; b.sign = 1'b1; b.negate = 1'b1; end
          3'b110: b.opt = OPT_LT;
          3'b111: begin b.opt = OPT_LT; b.negate = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        b.a1_sel = A1_RS1;
        b.a2_imm = 1'b1;
        b.opt    = OPT_ADD;
        b.cls    = CLS_LD;
        imm32    = imm_i(inst);
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) legal = 1'b0;
      end
      OP_STORE: begin
        b.a1_sel = A1_RS1;
        b.a2_imm = 1'b1;
        b.opt    = OPT_ADD;
        b.cls    = CLS_ST;
        imm32    = imm_s(inst);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        if (f3[2] || f3 == 3'b011) legal = 1'b0;
      end
      OP_OPIMM, OP_OP: begin
        b.a1_sel = A1_RS1;
        b.a2_imm = is_imm;
        b.cls    = CLS_ALU;
        imm32    = is_imm ? imm_i(inst) : '0;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = !is_imm;
        case (f3)
          3'b000: begin b.opt = OPT_ADD; b.ext = !is_imm && f7[5]; end
          3'b001: b.opt = OPT_SLL;
          3'b010: begin b.opt = OPT_LT; b.ext = 1'b1; b.sign = 1'b1; end
          3'b011: begin b.opt = OPT_LT; b.ext = 1'b1; end
          3'b100: b.opt = OPT_XOR;
          3'b101: begin b.opt = OPT_SR; b.sign = f7[5]; end
          3'b110: begin b.opt = OPT_ANDOR; b.ext = 1'b1; end
          default: b.opt = OPT_ANDOR;
        endcase
        // funct7 only matters for shift-immediates and register forms.
        if (is_imm) begin
          if (f3 == 3'b001 && f7 != 7'h00) legal = 1'b0;
          if (f3 == 3'b101 && !f7_std) legal = 1'b0;
        end else if (f3 == 3'b000 || f3 == 3'b101) begin
          if (!f7_std) legal = 1'b0;
        end else if (f7 != 7'h00) begin
          legal = 1'b0;
        end
      end
      OP_FENCE: begin
        b.cls = CLS_SYS;
        if (f3[2:1] != 2'b00) legal = 1'b0;
      end
      OP_SYSTEM: begin
        b.cls = CLS_SYS;
        if (inst != 32'h0000_0073 && inst != 32'h0010_0073) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (use_rd && idx_bad(inst[11:7])) legal = 1'b0;
    if (use_rs1 && idx_bad(inst[19:15])) legal = 1'b0;
    if (use_rs2 && idx_bad(inst[24:20])) legal = 1'b0;
    b.imm = XLEN'(imm32);
    b.wen = use_rd && legal && (inst[11:7] != 5'd0);
    if (!legal) begin
      b.cls    = CLS_ILL;
      b.opt    = '0;
      b.ext    = 1'b0;
      b.sign   = 1'b0;
      b.negate = 1'b0;
      b.snpc   = 1'b0;
      b.a1_sel = '0;
      b.a2_imm = 1'b0;
      b.wen    = 1'b0;
    end
    return b;
  endfunction

  // ---- p0: combinational decode of the incoming fetch bundle ----
  bundle_t w_dec_p0;
  logic    w_acc_p0;
  logic    w_drain_p1;

  bundle_t r_out_p1;
  logic    r_out_vld_p1;
  bundle_t r_skid_p1;
  logic    r_skid_vld_p1;
  logic    r_in_rdy;

  bundle_t w_out_nxt;
  logic    w_out_vld_nxt;
  bundle_t w_skid_nxt;
  logic    w_skid_vld_nxt;

  assign w_dec_p0   = decode(in_pc, in_inst);
  assign w_acc_p0   = in_valid && r_in_rdy;
  assign w_drain_p1 = r_out_vld_p1 && out_ready;

  // Skid is only ever filled while the output slot is full and stalled, and
  // in_ready is low whenever it holds data, so no accept can race its drain.
  always_comb begin
    w_out_nxt      = r_out_p1;
    w_out_vld_nxt  = r_out_vld_p1;
    w_skid_nxt     = r_skid_p1;
    w_skid_vld_nxt = r_skid_vld_p1;
    if (!r_out_vld_p1 || w_drain_p1) begin
      if (r_skid_vld_p1) begin
        w_out_nxt      = r_skid_p1;
        w_out_vld_nxt  = 1'b1;
        w_skid_vld_nxt = 1'b0;
      end else if (w_acc_p0) begin
        w_out_nxt     = w_dec_p0;
        w_out_vld_nxt = 1'b1;
      end else begin
        w_out_vld_nxt = 1'b0;
      end
    end else if (w_acc_p0) begin
      w_skid_nxt     = w_dec_p0;
      w_skid_vld_nxt = 1'b1;
    end
  end

  // ---- p1: registered output slot and skid entry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld_p1  <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_in_rdy      <= 1'b1;
      r_out_p1      <= '0;
      r_skid_p1     <= '0;
    end else begin
      r_out_vld_p1  <= w_out_vld_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
      r_in_rdy      <= !w_skid_vld_nxt;
      r_out_p1      <= w_out_nxt;
      r_skid_p1     <= w_skid_nxt;
    end
  end

  assign in_ready   = r_in_rdy;
  assign out_valid  = r_out_vld_p1;
  assign out_pc     = r_out_p1.pc;
  assign out_opt    = r_out_p1.opt;
  assign out_ext    = r_out_p1.ext;
  assign out_sign   = r_out_p1.sign;
  assign out_negate = r_out_p1.negate;
  assign out_snpc   = r_out_p1.snpc;
  assign out_a1_sel = r_out_p1.a1_sel;
  assign out_a2_imm = r_out_p1.a2_imm;
  assign out_imm    = r_out_p1.imm;
  assign out_rs1    = r_out_p1.rs1;
  assign out_rs2    = r_out_p1.rs2;
  assign out_rd     = r_out_p1.rd;
  assign out_wen    = r_out_p1.wen;
  assign out_class  = r_out_p1.cls;

endmodule

// File: tb/tb_ysyx_25040111_alu_dec.sv
// Directed bench for ysyx_25040111_alu_dec: decode table plus skid/reset sequences.
module tb_ysyx_25040111_alu_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_opt;
  logic        out_ext;
  logic        out_sign;
  logic        out_negate;
  logic        out_snpc;
  logic [1:0]  out_a1_sel;
  logic        out_a2_imm;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [2:0]  out_class;

  int n_chk = 0;
  int n_err = 0;

  ysyx_25040111_alu_dec #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opt(out_opt), .out_ext(out_ext), .out_sign(out_sign), .out_negate(out_negate),
    .out_snpc(out_snpc), .out_a1_sel(out_a1_sel), .out_a2_imm(out_a2_imm),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_wen(out_wen), .out_class(out_class)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  opt;
    logic        ext, sign, neg, snpc;
    logic [1:0]  a1;
    logic        a2;
    logic        chk_imm;
    logic [31:0] imm;
    logic        chk_rd;
    logic [4:0]  rd;
    logic        wen;
    logic [2:0]  cls;
    logic        chk_rs;
    logic [4:0]  rs1, rs2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] inst, input logic [2:0] opt,
                              input logic ext, input logic sign, input logic neg,
                              input logic snpc, input logic [1:0] a1, input logic a2,
                              input logic chk_imm, input logic [31:0] imm,
                              input logic chk_rd, input logic [4:0] rd, input logic wen,
                              input logic [2:0] cls, input logic chk_rs,
                              input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v.inst = inst; v.opt = opt; v.ext = ext; v.sign = sign; v.neg = neg; v.snpc = snpc;
    v.a1 = a1; v.a2 = a2; v.chk_imm = chk_imm; v.imm = imm; v.chk_rd = chk_rd; v.rd = rd;
    v.wen = wen; v.cls = cls; v.chk_rs = chk_rs; v.rs1 = rs1; v.rs2 = rs2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

    //          inst          opt ext sg ng sn a1 a2 ci imm           cr rd wen cls cs rs1 rs2
    vecs.push_back(mk(32'h00500093, 1, 0, 0, 0, 0, 0, 1, 1, 32'h5,        1, 1, 1, 0, 0, 0, 0)); // addi x1,x0,5
    vecs.push_back(mk(32'hFE209EE3, 7, 1, 0, 1, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 1, 1, 1, 2)); // bne -4
    vecs.push_back(mk(32'h0040006F, 1, 0, 0, 0, 1, 1, 0, 1, 32'h4,        1, 0, 0, 2, 0, 0, 0)); // jal x0,4
    vecs.push_back(mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 7, 0, 0, 0)); // illegal
    vecs.push_back(mk(32'h123452B7, 1, 0, 0, 0, 0, 2, 1, 1, 32'h12345000, 1, 5, 1, 0, 0, 0, 0)); // lui
    vecs.push_back(mk(32'h00001197, 1, 0, 0, 0, 0, 1, 1, 1, 32'h1000,     1, 3, 1, 0, 0, 0, 0)); // auipc
    vecs.push_back(mk(32'h402081B3, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 3, 1, 0, 1, 1, 2)); // sub
    vecs.push_back(mk(32'h4020D233, 5, 0, 1, 0, 0, 0, 0, 0, 32'h0,        1, 4, 1, 0, 1, 1, 2)); // sra
    vecs.push_back(mk(32'hFFF0B313, 6, 1, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 1, 6, 1, 0, 0, 0, 0)); // sltiu -1
    vecs.push_back(mk(32'h0F00E393, 2, 1, 0, 0, 0, 0, 1, 1, 32'hF0,       1, 7, 1, 0, 0, 0, 0)); // ori
    vecs.push_back(mk(32'h0020D463, 6, 1, 1, 1, 0, 0, 0, 1, 32'h8,        0, 0, 0, 1, 1, 1, 2)); // bge +8
    vecs.push_back(mk(32'hFFC12403, 1, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 1, 8, 1, 3, 0, 0, 0)); // lw
    vecs.push_back(mk(32'h0020A423, 1, 0, 0, 0, 0, 0, 1, 1, 32'h8,        0, 0, 0, 4, 1, 1, 2)); // sw
    vecs.push_back(mk(32'h00000073, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 5, 0, 0, 0)); // ecall
    vecs.push_back(mk(32'h0230D093, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 7, 0, 0, 0)); // srli bad f7
    vecs.push_back(mk(32'h4030D093, 5, 0, 1, 0, 0, 0, 1, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0)); // srai
    vecs.push_back(mk(32'h000280E7, 1, 0, 0, 0, 1, 1, 0, 1, 32'h0,        1, 1, 1, 2, 0, 0, 0)); // jalr
    vecs.push_back(mk(32'h00208033, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 1, 1, 2)); // add x0
    vecs.push_back(mk(32'h0020C4B3, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 9, 1, 0, 1, 1, 2)); // xor
    vecs.push_back(mk(32'h0020E463, 6, 1, 0, 0, 0, 0, 0, 1, 32'h8,        0, 0, 0, 1, 1, 1, 2)); // bltu
    vecs.push_back(mk(32'h0000000F, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 5, 0, 0, 0)); // fence
    vecs.push_back(mk(32'h00003003, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 7, 0, 0, 0)); // load f3=011

    repeat (2) tick();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_pc", out_pc, 0);
    chk("rst out_imm", out_imm, 0);
    chk("rst out_opt", 32'(out_opt), 0);
    chk("rst out_wen", 32'(out_wen), 0);
    rst_n = 1'b1;
    tick();
    chk("idle out_valid", 32'(out_valid), 0);
    chk("idle in_ready", 32'(in_ready), 1);

    // Back-to-back stream with out_ready high: each vector appears one edge later.
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t  v;
      string t;
      v = vecs[i];
      send(32'h8000_0000 + 32'(i) * 4, v.inst);
      tick();
      t = $sformatf("v%0d_%08h", i, v.inst);
      chk({t, " valid"}, 32'(out_valid), 1);
      chk({t, " in_ready"}, 32'(in_ready), 1);
      chk({t, " pc"}, out_pc, 32'h8000_0000 + 32'(i) * 4);
      chk({t, " opt"}, 32'(out_opt), 32'(v.opt));
      chk({t, " ext"}, 32'(out_ext), 32'(v.ext));
      chk({t, " sign"}, 32'(out_sign), 32'(v.sign));
      chk({t, " negate"}, 32'(out_negate), 32'(v.neg));
      chk({t, " snpc"}, 32'(out_snpc), 32'(v.snpc));
      chk({t, " a1_sel"}, 32'(out_a1_sel), 32'(v.a1));
      chk({t, " a2_imm"}, 32'(out_a2_imm), 32'(v.a2));
      chk({t, " wen"}, 32'(out_wen), 32'(v.wen));
      chk({t, " class"}, 32'(out_class), 32'(v.cls));
      if (v.chk_imm) chk({t, " imm"}, out_imm, v.imm);
      if (v.chk_rd) chk({t, " rd"}, 32'(out_rd), 32'(v.rd));
      if (v.chk_rs) begin
        chk({t, " rs1"}, 32'(out_rs1), 32'(v.rs1));
        chk({t, " rs2"}, 32'(out_rs2), 32'(v.rs2));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("drain out_valid", 32'(out_valid), 0);

    // Stalled output: A fills output, B fills skid, C is refused until release.
    out_ready = 1'b0;
    send(32'h0000_1000, 32'h00500093);
    tick();
    chk("skid A out_pc", out_pc, 32'h0000_1000);
    chk("skid A in_ready", 32'(in_ready), 1);
    send(32'h0000_1004, 32'h402081B3);
    tick();
    chk("skid B in_ready", 32'(in_ready), 0);
    chk("skid B out_pc", out_pc, 32'h0000_1000);
    send(32'h0000_1008, 32'h0040006F);
    tick();
    chk("skid C refused in_ready", 32'(in_ready), 0);
    chk("skid C out_valid", 32'(out_valid), 1);
    chk("skid C out_pc held", out_pc, 32'h0000_1000);
    chk("skid C opt held", 32'(out_opt), 1);
    out_ready = 1'b1;
    tick();
    chk("release B out_pc", out_pc, 32'h0000_1004);
    chk("release B ext", 32'(out_ext), 1);
    chk("release in_ready", 32'(in_ready), 1);
    tick();
    chk("release C out_pc", out_pc, 32'h0000_1008);
    chk("release C class", 32'(out_class), 2);
    in_valid = 1'b0;
    tick();
    chk("release empty", 32'(out_valid), 0);

    // Asynchronous reset while both entries are full.
    out_ready = 1'b0;
    send(32'h0000_2000, 32'h00500093);
    tick();
    send(32'h0000_2004, 32'hFFFFFFFF);
    tick();
    in_valid = 1'b0;
    chk("pre-rst in_ready", 32'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 0);
    chk("async rst in_ready", 32'(in_ready), 1);
    chk("async rst out_pc", out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post-rst no replay", 32'(out_valid), 0);
    tick();
    chk("post-rst still empty", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
